shift_seq_engine: RTL and testbench
===================================

Name: shift_seq_engine

Overview:
- Parametrised, multi-mode sequential shift engine; successor to the fixed 8-bit, compile-time-direction shift register.
- Width and shift mode are selectable, plus serial in/out and a start/busy/done handshake.
- Shifts one bit position per clock for a run-time amount, so the shift is multi-cycle, not a barrel shift.
- Sits in datapaths that need serialisation or normalisation under control-FSM sequencing.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, $clog2(WIDTH+1), width of amount input and internal down-counter (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (asserts immediately when low, released synchronously by the user)
load  input  1  parallel load strobe
load_value  input  WIDTH  parallel load data
start  input  1  single-cycle request to begin a shift run
mode  input  3  shift mode, sampled with start
amount  input  CNT_W  number of single-bit shift steps, sampled with start
si  input  1  serial fill bit for LSL/LSR, sampled every step
po  output  WIDTH  register contents
so  output  1  last bit shifted out
busy  output  1  run in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0): po=0, so=0, busy=0, done=0, counter=0, state=IDLE, latched mode=000.
- States:
  - IDLE: waiting for load or start.
  - SHIFT: one step per clock.
  - FIN: asserts done for one cycle, then returns to IDLE.
- Modes, one step each:
  - 000 LSL: po<={po[W-2:0],si}, so<=po[W-1].
  - 001 LSR: po<={si,po[W-1:1]}, so<=po[0].
  - 010 ASR: po<={po[W-1],po[W-1:1]}, so<=po[0].
  - 011 ROL: po<={po[W-2:0],po[W-1]}, so<=po[W-1].
  - 100 ROR: po<={po[0],po[W-1:1]}, so<=po[0].
  - 101–111 reserved: po and so hold; counter still decrements, and done is still produced.
- IDLE + start, amount>0:
  - Latch mode; counter<=amount; go to SHIFT; busy=1 from the next cycle.
  - No shift occurs in the start cycle.
- IDLE + start, amount=0: go to FIN directly; done=1 on the next cycle; po unchanged; busy stays 0.
- SHIFT:
  - Each cycle, perform one step and decrement the counter.
  - When the counter reaches 1, the final step occurs and state goes to FIN.
  - Latency: start at edge k → last step at edge k+amount → done high during the cycle after that edge. Total start-to-done = amount+1 cycles.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- Amounts >= WIDTH are legal and executed literally:
  - Logical modes end fully filled with si history.
  - ASR saturates to sign fill.
  - Rotates wrap (amount=WIDTH restores the original value).
- load priority:
  - load beats start and beats an in-progress run.
  - load in SHIFT or FIN aborts: po<=load_value, state<=IDLE, busy=0, no done pulse, so unchanged.
  - load and start in the same IDLE cycle: load wins and start is dropped.
- start while busy (SHIFT/FIN) is ignored; mode/amount/si changes mid-run do not affect the latched mode.
- Reset mid-run: immediate return to reset values; done never asserts.
- busy=1 exactly in SHIFT; done=1 exactly in FIN.

Test Plan:
- WIDTH=8. Reset low with po preloaded → po=0x00, so=0, busy=0, done=0 asynchronously, without waiting for a clock edge.
- load 0xB4, then start mode=000 amount=3 si=1 → busy for 3 cycles; po 0x69, 0xD3, 0xA7; so=1 at the end; done one cycle after the last step, cycle count start→done = 4.
- load 0x90, start mode=010 amount=2 → po 0xC8 then 0xE4, so=0. Then start mode=001 amount=9 si=0 → po=0x00, done after 10 cycles.
- load 0x81, start mode=011 amount=8 → po returns to 0x81. Then mode=100 amount=1 → po=0xC0, so=1.
- start amount=0 → done pulse next cycle, busy never high, po unchanged. start with mode=110 amount=2 → po held, done after 3 cycles.
- Abort and interaction cases:
  - load 0x3C mid-run (after 1 step) → po=0x3C, busy=0, no done.
  - start asserted during busy → ignored.
  - load+start together → load only.
  - Reset asserted mid-run → outputs zeroed, no done.

Source files
------------

// File: rtl/shift_seq_engine.sv
// Multi-cycle shift engine: moves the register one bit per clock for a run-time
// amount, with serial fill, a one-cycle done pulse, and a parallel-load abort.
module shift_seq_engine #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] step_po;
    logic             step_so;

    // One step of the latched mode; reserved modes leave po/so untouched.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        step_po = po;
        step_so = so;
        case (mode_q)
            MODE_LSL: begin
                step_po = {po[WIDTH-2:0], si};
                step_so = po[WIDTH-1];
            end
            MODE_LSR: begin
                step_po = {si, po[WIDTH-1:1]};
                step_so = po[0];
            end
            MODE_ASR: begin
                step_po = {po[WIDTH-1], po[WIDTH-1:1]};
                step_so = po[0];
            end
            MODE_ROL: begin
                step_po = {po[WIDTH-2:0], po[WIDTH-1]};
                step_so = po[WIDTH-1];
            end
            MODE_ROR: begin
                step_po = {po[0], po[WIDTH-1:1]};
                step_so = po[0];
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments throughout so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= CNT_ZERO;
            mode_q <= MODE_LSL;
            po     <= '0;
            so     <= 1'b0;
        end else if (load) begin
            // Load wins over start and aborts any run without a done pulse.
            po    <= load_value;
            state <= ST_IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        cnt    <= amount;
                        state  <= (amount == CNT_ZERO) ? ST_FIN : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    po  <= step_po;
                    so  <= step_so;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_shift_seq_engine.sv
// Directed bench for shift_seq_engine (WIDTH=8) with hand-computed expectations.
module tb_shift_seq_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             si;
    logic [WIDTH-1:0] po;
    logic             so;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    shift_seq_engine #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .mode       (mode),
        .amount     (amount),
        .si         (si),
        .po         (po),
        .so         (so),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1;
        load_value = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] m, input logic [CNT_W-1:0] a, input logic s);
        mode = m;
        amount = a;
        si = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles (start cycle = 0) until done, and how many of them had busy high.
    task automatic wait_done(input int first_cyc, output int cyc, output int busy_cnt);
        cyc = first_cyc;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;

        rst = 1'b0;
        load = 1'b0;
        load_value = '0;
        start = 1'b0;
        mode = 3'b000;
        amount = '0;
        si = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Asynchronous reset with po preloaded
        do_load(8'hA5);
        check("preload", po, 8'hA5);
        #2 rst = 1'b0;
        #1;
        check("rst_po", po, 8'h00);
        check("rst_so", so, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // LSL 3 with si=1 on 0xB4
        do_load(8'hB4);
        do_start(3'b000, 4'd3, 1'b1);
        check("lsl_c1_po", po, 8'hB4);
        check("lsl_c1_busy", busy, 1'b1);
        tick();
        check("lsl_s1", po, 8'h69);
        tick();
        check("lsl_s2", po, 8'hD3);
        check("lsl_s2_busy", busy, 1'b1);
        tick();
        check("lsl_s3", po, 8'hA7);
        check("lsl_so", so, 1'b1);
        check("lsl_done", done, 1'b1);
        check("lsl_fin_busy", busy, 1'b0);
        tick();
        check("lsl_done_pulse", done, 1'b0);

        // Latency check by cycle count
        do_load(8'hB4);
        do_start(3'b000, 4'd3, 1'b1);
        wait_done(1, cyc, bcnt);
        check("lsl_latency", cyc, 4);
        check("lsl_busy_cycles", bcnt, 3);
        tick();

        // ASR 2 on 0x90
        do_load(8'h90);
        do_start(3'b010, 4'd2, 1'b0);
        tick();
        check("asr_s1", po, 8'hC8);
        tick();
        check("asr_s2", po, 8'hE4);
        check("asr_so", so, 1'b0);
        check("asr_done", done, 1'b1);
        tick();

        // LSR 9 (> WIDTH) with si=0
        do_start(3'b001, 4'd9, 1'b0);
        wait_done(1, cyc, bcnt);
        check("lsr9_latency", cyc, 10);
        check("lsr9_po", po, 8'h00);
        check("lsr9_so", so, 1'b0);
        tick();

        // ROL 8 restores the value, then ROR 1
        do_load(8'h81);
        do_start(3'b011, 4'd8, 1'b0);
        wait_done(1, cyc, bcnt);
        check("rol8_latency", cyc, 9);
        check("rol8_po", po, 8'h81);
        check("rol8_so", so, 1'b1);
        tick();
        do_start(3'b100, 4'd1, 1'b0);
        wait_done(1, cyc, bcnt);
        check("ror1_latency", cyc, 2);
        check("ror1_po", po, 8'hC0);
        check("ror1_so", so, 1'b1);
        tick();

        // amount=0: done next cycle, never busy, po unchanged
        do_start(3'b000, 4'd0, 1'b1);
        check("amt0_done", done, 1'b1);
        check("amt0_busy", busy, 1'b0);
        check("amt0_po", po, 8'hC0);
        tick();
        check("amt0_pulse", done, 1'b0);

        // Reserved mode: po/so hold, done still after amount+1 cycles
        do_start(3'b110, 4'd2, 1'b0);
        wait_done(1, cyc, bcnt);
        check("rsv_latency", cyc, 3);
        check("rsv_po", po, 8'hC0);
        check("rsv_so", so, 1'b1);
        tick();

        // Load aborts a run after one step; so unchanged, no done
        do_load(8'h55);
        do_start(3'b000, 4'd5, 1'b1);
        tick();
        check("abort_s1", po, 8'hAB);
        do_load(8'h3C);
        check("abort_po", po, 8'h3C);
        check("abort_busy", busy, 1'b0);
        check("abort_so", so, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcnt++;
            tick();
        end
        check("abort_no_done", dcnt, 0);
        check("abort_po_hold", po, 8'h3C);

        // Start while busy is ignored; mid-run input changes do not matter
        do_start(3'b100, 4'd3, 1'b0);
        mode = 3'b000;
        amount = 4'd1;
        si = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2, cyc, bcnt);
        check("busy_start_latency", cyc, 4);
        check("busy_start_po", po, 8'h87);
        check("busy_start_so", so, 1'b1);
        tick();
        check("busy_start_idle", busy, 1'b0);

        // Load and start together: load only
        load = 1'b1;
        load_value = 8'hF0;
        mode = 3'b000;
        amount = 4'd2;
        si = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        check("ldst_po", po, 8'hF0);
        check("ldst_busy", busy, 1'b0);
        tick();
        check("ldst_done", done, 1'b0);
        check("ldst_po_hold", po, 8'hF0);

        // Reset mid-run
        do_load(8'hFF);
        do_start(3'b000, 4'd5, 1'b0);
        tick();
        check("rstmid_s1", po, 8'hFE);
        #2 rst = 1'b0;
        #1;
        check("rstmid_po", po, 8'h00);
        check("rstmid_so", so, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        tick();
        rst = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        check("rstmid_no_done", dcnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
